// File: rtl/ball_server_pkg.sv
// rtl/ball_server_pkg.sv - shared constants and state encoding for the serve/respawn controller
//
// Holds the ball start-position constants, the default hold length and the
// two-bit state encoding used by ball_server.
package ball_server_pkg;

  localparam logic [9:0] BALLX           = 10'd160;
  localparam logic [9:0] BALLY           = 10'd200;
  localparam logic [7:0] HOLD_FRAMES_DEF = 8'd60;

  typedef enum logic [1:0] {
    WAIT_LAUNCH = 2'd0,
    PLAY        = 2'd1,
    HOLD        = 2'd2,
    GAME_OVER   = 2'd3
  } state_t;

endpackage

// File: rtl/ball_server_edge_detect.sv
// rtl/ball_server_edge_detect.sv - 1-bit rising-edge detector with configurable reset value
//
// Ports:
//   clk    in  system clock
//   resetn in  asynchronous active-low reset
//   d      in  level input (already synchronised)
//   rise   out combinational: d is high now and was low last cycle
//
// RESET_VAL = 1 makes a level that is already high when reset is released
// look "old", so it must drop and rise again before an edge is reported.
module edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= RESET_VAL;
    end else begin
      q <= d;
    end
  end

  assign rise = d & ~q;

endmodule

// File: rtl/ball_server.sv
// rtl/ball_server.sv - serve/respawn controller: freezes, reloads and relaunches the ball
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   tick          one-cycle frame strobe
//   life_lost     one-cycle pulse, a life was spent
//   game_over     level, health exhausted (sticky GAME_OVER until reset)
//   launch        launch button level (synchronised)
//   ball_hold     1 = ball motion frozen
//   ball_load     one-cycle pulse, ball loads ball_x_init / ball_y_init
//   ball_x_init   constant START_X
//   ball_y_init   constant START_Y
//   dir_x         serve x direction, valid while ball_hold = 1
//   dir_y         constant 0 (upward)
//   serve_count   launches since reset, saturating at 255
//   dead          1 = GAME_OVER
module ball_server
  import ball_server_pkg::*;
#(
  parameter logic [9:0] START_X     = BALLX,
  parameter logic [9:0] START_Y     = BALLY,
  parameter logic [7:0] HOLD_FRAMES = HOLD_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic       life_lost,
  input  logic       game_over,
  input  logic       launch,
  output logic       ball_hold,
  output logic       ball_load,
  output logic [9:0] ball_x_init,
  output logic [9:0] ball_y_init,
  output logic       dir_x,
  output logic       dir_y,
  output logic [7:0] serve_count,
  output logic       dead
);

  state_t     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       launch_rise;
  logic       serve;
  logic       load_d;

  // Reset value 1: a button held through reset must be released before it serves.
  edge_detect #(.RESET_VAL(1'b1)) u_launch_edge (
    .clk    (clk),
    .resetn (resetn),
    .d      (launch),
    .rise   (launch_rise)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    serve      = 1'b0;
    load_d     = 1'b0;

    case (state_q)
      WAIT_LAUNCH: begin
        if (launch_rise) begin
          state_d = PLAY;
          serve   = 1'b1;
        end
      end
      PLAY: begin
        // A tick in the same cycle as the loss is not counted.
        if (life_lost) begin
          state_d    = HOLD;
          hold_cnt_d = 8'd0;
        end
      end
      HOLD: begin
        if (tick) begin
          if (hold_cnt_q == HOLD_FRAMES - 8'd1) begin
            state_d    = WAIT_LAUNCH;
            hold_cnt_d = 8'd0;
            load_d     = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end
      end
      GAME_OVER: begin
        state_d = GAME_OVER;
      end
    endcase

    // game_over overrides any serve, reload or counting in the same cycle.
    if (game_over) begin
      state_d    = GAME_OVER;
      hold_cnt_d = hold_cnt_q;
      serve      = 1'b0;
      load_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= WAIT_LAUNCH;
      hold_cnt_q  <= 8'd0;
      ball_hold   <= 1'b1;
      ball_load   <= 1'b0;
      dead        <= 1'b0;
      serve_count <= 8'd0;
      dir_x       <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      // Outputs follow the next state so they line up with the state register.
      ball_hold  <= (state_d != PLAY);
      ball_load  <= load_d;
      dead       <= (state_d == GAME_OVER);
      if (serve) begin
        if (serve_count != 8'd255) begin
          serve_count <= serve_count + 8'd1;
        end
        dir_x <= ~dir_x;
      end
    end
  end

  assign ball_x_init = START_X;
  assign ball_y_init = START_Y;
  assign dir_y       = 1'b0;

endmodule

// File: tb/tb_ball_server.sv
// tb/tb_ball_server.sv - directed table-driven bench for ball_server
module tb_ball_server;

  logic       clk;
  logic       resetn;
  logic       tick;
  logic       life_lost;
  logic       game_over;
  logic       launch;
  logic       ball_hold;
  logic       ball_load;
  logic [9:0] ball_x_init;
  logic [9:0] ball_y_init;
  logic       dir_x;
  logic       dir_y;
  logic [7:0] serve_count;
  logic       dead;

  int n_checks = 0;
  int n_fail   = 0;

  ball_server #(.HOLD_FRAMES(8'd4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .tick        (tick),
    .life_lost   (life_lost),
    .game_over   (game_over),
    .launch      (launch),
    .ball_hold   (ball_hold),
    .ball_load   (ball_load),
    .ball_x_init (ball_x_init),
    .ball_y_init (ball_y_init),
    .dir_x       (dir_x),
    .dir_y       (dir_y),
    .serve_count (serve_count),
    .dead        (dead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       tk;
    logic       ll;
    logic       go;
    logic       ln;
    logic [1:0] st;
    logic       hold;
    logic       load;
    logic       dirx;
    logic [7:0] cnt;
    logic       dd;
    int         hc;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic tk, logic ll, logic go, logic ln, logic [1:0] st,
                              logic hold, logic load, logic dirx, logic [7:0] cnt,
                              logic dd, int hc);
    vec_t v;
    v.tk = tk; v.ll = ll; v.go = go; v.ln = ln; v.st = st; v.hold = hold;
    v.load = load; v.dirx = dirx; v.cnt = cnt; v.dd = dd; v.hc = hc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic tk, input logic ll, input logic go, input logic ln);
    @(negedge clk);
    tick = tk; life_lost = ll; game_over = go; launch = ln;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ln);
    @(negedge clk);
    resetn = 1'b0;
    tick = 1'b0; life_lost = 1'b0; game_over = 1'b0; launch = ln;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  int loads;
  int load_ok;

  initial begin
    resetn = 1'b0; tick = 1'b0; life_lost = 1'b0; game_over = 1'b0; launch = 1'b0;

    // state: 0 WAIT, 1 PLAY, 2 HOLD, 3 GAME_OVER; hc = -1 means not checked
    vecs[0]  = mk(0,0,0,0, 2'd0, 1,0,0, 8'd0, 0, 0);
    vecs[1]  = mk(0,0,0,1, 2'd1, 0,0,1, 8'd1, 0, -1);
    vecs[2]  = mk(0,0,0,1, 2'd1, 0,0,1, 8'd1, 0, -1);
    vecs[3]  = mk(1,0,0,0, 2'd1, 0,0,1, 8'd1, 0, -1);
    vecs[4]  = mk(1,1,0,0, 2'd2, 1,0,1, 8'd1, 0, 0);
    vecs[5]  = mk(1,0,0,0, 2'd2, 1,0,1, 8'd1, 0, 1);
    vecs[6]  = mk(0,0,0,0, 2'd2, 1,0,1, 8'd1, 0, 1);
    vecs[7]  = mk(1,0,0,0, 2'd2, 1,0,1, 8'd1, 0, 2);
    vecs[8]  = mk(1,0,0,1, 2'd2, 1,0,1, 8'd1, 0, 3);
    vecs[9]  = mk(0,1,0,1, 2'd2, 1,0,1, 8'd1, 0, 3);
    vecs[10] = mk(1,0,0,1, 2'd0, 1,1,1, 8'd1, 0, -1);
    vecs[11] = mk(0,0,0,1, 2'd0, 1,0,1, 8'd1, 0, -1);
    vecs[12] = mk(0,0,0,0, 2'd0, 1,0,1, 8'd1, 0, -1);
    vecs[13] = mk(0,1,0,0, 2'd0, 1,0,1, 8'd1, 0, -1);
    vecs[14] = mk(0,0,0,1, 2'd1, 0,0,0, 8'd2, 0, -1);
    vecs[15] = mk(0,1,1,0, 2'd3, 1,0,0, 8'd2, 1, -1);
    vecs[16] = mk(0,0,0,1, 2'd3, 1,0,0, 8'd2, 1, -1);
    vecs[17] = mk(1,1,0,1, 2'd3, 1,0,0, 8'd2, 1, -1);
    vecs[18] = mk(0,0,0,0, 2'd3, 1,0,0, 8'd2, 1, -1);
    vecs[19] = mk(0,1,0,1, 2'd3, 1,0,0, 8'd2, 1, -1);

    // Reset values while reset is held
    #12;
    chk("rst_state", int'(dut.state_q), 0);
    chk("rst_hold", int'(ball_hold), 1);
    chk("rst_load", int'(ball_load), 0);
    chk("rst_dead", int'(dead), 0);
    chk("rst_cnt", int'(serve_count), 0);
    chk("rst_dirx", int'(dir_x), 0);
    chk("rst_hc", int'(dut.hold_cnt_q), 0);
    chk("x_init", int'(ball_x_init), 160);
    chk("y_init", int'(ball_y_init), 200);
    chk("dir_y", int'(dir_y), 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].tk, vecs[i].ll, vecs[i].go, vecs[i].ln);
      chk($sformatf("v%0d_state", i), int'(dut.state_q), int'(vecs[i].st));
      chk($sformatf("v%0d_hold", i), int'(ball_hold), int'(vecs[i].hold));
      chk($sformatf("v%0d_load", i), int'(ball_load), int'(vecs[i].load));
      chk($sformatf("v%0d_dirx", i), int'(dir_x), int'(vecs[i].dirx));
      chk($sformatf("v%0d_cnt", i), int'(serve_count), int'(vecs[i].cnt));
      chk($sformatf("v%0d_dead", i), int'(dead), int'(vecs[i].dd));
      if (vecs[i].hc >= 0) chk($sformatf("v%0d_hc", i), int'(dut.hold_cnt_q), vecs[i].hc);
    end

    // Launch held across reset release: no serve until a fresh edge
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      chk("held_rst_cnt", int'(serve_count), 0);
      chk("held_rst_state", int'(dut.state_q), 0);
      chk("held_rst_hold", int'(ball_hold), 1);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("fresh_press_state", int'(dut.state_q), 1);
    chk("fresh_press_cnt", int'(serve_count), 1);

    // Loss, then 4 ticks spaced 10 cycles apart; exactly one load pulse after the 4th
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    loads = 0;
    load_ok = 0;
    for (int t = 1; t <= 4; t++) begin
      for (int c = 0; c < 9; c++) begin
        step(0, 0, 0, 0);
        chk("spaced_hold", int'(ball_hold), 1);
        if (ball_load) loads++;
      end
      step(1, 0, 0, 0);
      chk("spaced_hold", int'(ball_hold), 1);
      if (ball_load) begin
        loads++;
        if (t == 4) load_ok = 1;
      end
    end
    step(0, 0, 0, 0);
    if (ball_load) loads++;
    chk("spaced_load_count", loads, 1);
    chk("spaced_load_timing", load_ok, 1);
    chk("spaced_state", int'(dut.state_q), 0);
    chk("spaced_x", int'(ball_x_init), 160);
    chk("spaced_y", int'(ball_y_init), 200);

    // Asynchronous reset mid-HOLD with counter = 2
    do_reset(1'b0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("midhold_hc", int'(dut.hold_cnt_q), 2);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_state", int'(dut.state_q), 0);
    chk("midrst_hc", int'(dut.hold_cnt_q), 0);
    chk("midrst_load", int'(ball_load), 0);
    chk("midrst_hold", int'(ball_hold), 1);
    chk("midrst_cnt", int'(serve_count), 0);
    chk("midrst_dirx", int'(dir_x), 0);
    @(negedge clk);
    resetn = 1'b1;

    // 256 serve/loss cycles: count saturates at 255, dir_x toggled an even number of times
    step(0, 0, 0, 0);
    for (int n = 0; n < 256; n++) begin
      step(0, 0, 0, 1);
      step(0, 1, 0, 0);
      for (int t = 0; t < 4; t++) step(1, 0, 0, 0);
      if (n == 254) chk("sat_cnt_255", int'(serve_count), 255);
    end
    chk("sat_cnt_final", int'(serve_count), 255);
    chk("sat_dirx", int'(dir_x), 0);
    chk("sat_state", int'(dut.state_q), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_server.md
Name: ball_server

Overview:
- Serve/respawn controller; the reaction end of the life-loss path.
- Consumes the per-life loss pulse and the terminal game-over flag from the loss checker.
- Freezes the ball, waits a fixed number of frames, then reloads the ball to its start position.
- Waits for a fresh launch press, then releases the ball with a serve direction.
- Sits between the loss checker / input logic and the ball motion datapath.

Parameters:
- START_X, 10'd160, ball x reload value (same value as the shared BALLX constant).
- START_Y, 10'd200, ball y reload value (same value as the shared BALLY constant).
- HOLD_FRAMES, 8'd60, frames to hold the ball after a life is lost; legal range 1..255.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset; asynchronous, active-low
- tick  in  1  one-cycle frame strobe
- life_lost  in  1  one-cycle pulse: ball crossed the platform line and a life was spent
- game_over  in  1  level: health exhausted
- launch  in  1  launch button level, active high, already synchronised
- ball_hold  out  1  1 = ball motion frozen
- ball_load  out  1  one-cycle pulse: ball loads ball_x_init / ball_y_init
- ball_x_init  out  10  reload x, constant START_X
- ball_y_init  out  10  reload y, constant START_Y
- dir_x  out  1  serve x direction (0 = left, 1 = right); valid whenever ball_hold = 1
- dir_y  out  1  serve y direction, constant 0 (upward)
- serve_count  out  8  number of launches since reset, saturates at 255
- dead  out  1  1 = GAME_OVER state

Behaviour:
- States: WAIT_LAUNCH, PLAY, HOLD, GAME_OVER.
- Reset values:
  - state = WAIT_LAUNCH
  - ball_hold = 1, ball_load = 0, dead = 0
  - serve_count = 0, dir_x = 0
  - hold counter = 0, launch_q = 1
- launch_q = 1 at reset means a button held through reset does not serve.
- Launch edge detect: launch_rise = launch & ~launch_q; launch_q <= launch every cycle in every state.
- WAIT_LAUNCH:
  - ball_hold = 1.
  - On launch_rise -> PLAY next cycle.
  - serve_count increments in the same cycle (saturating at 255).
  - dir_x toggles after the increment, so the next serve goes the other way.
- PLAY:
  - ball_hold = 0.
  - On life_lost -> HOLD; ball_hold = 1 from the next cycle; hold counter cleared.
- HOLD:
  - ball_hold = 1; the hold counter increments on each tick.
  - When tick arrives with counter == HOLD_FRAMES-1 -> WAIT_LAUNCH.
  - ball_load pulses high for exactly the first cycle in WAIT_LAUNCH (registered, one cycle after the transition).
  - life_lost and launch_rise are ignored in HOLD.
  - A press that starts during HOLD and is still held at exit does not serve; a new rising edge is required.
- GAME_OVER:
  - Entered from any state when game_over = 1; takes priority over every other event in the same cycle.
  - ball_hold = 1, dead = 1, no ball_load.
  - Sticky until resetn.
- Initial serve after reset: no ball_load pulse; the ball datapath resets to its own start position.
- life_lost outside PLAY is ignored; no queuing.
- life_lost and tick in the same PLAY cycle: go to HOLD; that tick is not counted.
- Reset mid-HOLD or mid-serve: asynchronous return to reset values, regardless of tick or launch.
- Hold counter: 8 bits, unsigned.
- All outputs are registered except ball_x_init, ball_y_init and dir_y, which are constants.

Decomposition:
- Shared macros package holds:
  - the BALLX / BALLY start-position constants, used as START_X / START_Y defaults
  - the state encodings (2 bits: WAIT_LAUNCH = 0, PLAY = 1, HOLD = 2, GAME_OVER = 3)
  - the HOLD_FRAMES default
- One natural sub-module: edge_detect.
  - 1-bit rising-edge detector with a parameterised reset value.
  - Reusable by other button inputs.

Test Plan:
- Reset, then launch 0->1 -> one cycle later state = PLAY, ball_hold = 0, serve_count = 1, dir_x = 1, no ball_load seen.
- HOLD_FRAMES = 4; in PLAY pulse life_lost, then 4 ticks spaced 10 cycles apart -> ball_hold = 1 throughout; ball_load high for exactly 1 cycle, one cycle after the 4th tick; state = WAIT_LAUNCH; ball_x_init = 160, ball_y_init = 200.
- Hold launch high from mid-HOLD through WAIT_LAUNCH entry -> no serve; release, then press again -> PLAY; serve_count = 2, dir_x = 0.
- life_lost and game_over in the same cycle during PLAY -> GAME_OVER; dead = 1, ball_hold = 1; further launch presses and life_lost pulses produce no change; ball_load never pulses.
- Launch held high across resetn deassertion -> no serve, serve_count stays 0.
- Reset asserted mid-HOLD (counter = 2) -> immediate WAIT_LAUNCH defaults; counter = 0, ball_load = 0.
- 256 launch/loss cycles -> serve_count saturates at 255.
- life_lost pulsed in WAIT_LAUNCH -> ignored; state unchanged.
